// File: rtl/phase_freq_detector.sv
// Phase/frequency detector: synchronizes ref/fb, measures rising-edge separation in clk_i
// cycles, and drives up/dn levels, a signed saturating error word and a slip strobe.
module phase_freq_detector #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             ref_i,
    input  logic             fb_i,
    output logic             up_o,
    output logic             dn_o,
    output logic [CNT_W-1:0] err_o,
    output logic             err_valid_o,
    output logic             slip_o
);

    localparam int unsigned MAG_W = CNT_W - 1;
    localparam logic [MAG_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        FB_LEAD  = 2'd2
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] ref_sync_q;
    logic [SYNC_STAGES-1:0] fb_sync_q;
    logic                   ref_prev_q;
    logic                   fb_prev_q;
    logic [MAG_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       err_q;
    logic                   err_valid_q;
    logic                   slip_q;

    logic                   r_ev;
    logic                   f_ev;
    logic [MAG_W-1:0]       cnt_sat_d;
    logic [CNT_W-1:0]       err_pos_d;
    logic [CNT_W-1:0]       err_neg_d;

    // Synchronizers and edge registers run regardless of enable so re-enable sees no stale edge.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ref_sync_q <= '0;
            fb_sync_q  <= '0;
            ref_prev_q <= 1'b0;
            fb_prev_q  <= 1'b0;
        end else begin
            ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], ref_i};
            fb_sync_q  <= {fb_sync_q[SYNC_STAGES-2:0], fb_i};
            ref_prev_q <= ref_sync_q[SYNC_STAGES-1];
            fb_prev_q  <= fb_sync_q[SYNC_STAGES-1];
        end
    end

    assign r_ev = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
    assign f_ev = fb_sync_q[SYNC_STAGES-1] & ~fb_prev_q;

    assign cnt_sat_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + MAG_W'(1);
    assign err_pos_d = {1'b0, cnt_q};
    assign err_neg_d = CNT_W'(0) - {1'b0, cnt_q};

    // Measurement FSM; strobes default low every cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= '0;
            err_valid_q <= 1'b0;
            slip_q      <= 1'b0;
        end else begin
            err_valid_q <= 1'b0;
            slip_q      <= 1'b0;
            if (!enable_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (r_ev && f_ev) begin
                            err_q       <= '0;
                            err_valid_q <= 1'b1;
                        end else if (r_ev) begin
                            state_q <= REF_LEAD;
                            cnt_q   <= MAG_W'(1);
                        end else if (f_ev) begin
                            state_q <= FB_LEAD;
                            cnt_q   <= MAG_W'(1);
                        end
                    end
                    REF_LEAD: begin
                        if (f_ev) begin
                            err_q       <= err_pos_d;
                            err_valid_q <= 1'b1;
                            if (r_ev) begin
                                cnt_q <= MAG_W'(1);
                            end else begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end
                        end else begin
                            cnt_q  <= cnt_sat_d;
                            slip_q <= r_ev;
                        end
                    end
                    FB_LEAD: begin
                        if (r_ev) begin
                            err_q       <= err_neg_d;
                            err_valid_q <= 1'b1;
                            if (f_ev) begin
                                cnt_q <= MAG_W'(1);
                            end else begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                            end
                        end else begin
                            cnt_q  <= cnt_sat_d;
                            slip_q <= f_ev;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign up_o        = (state_q == REF_LEAD);
    assign dn_o        = (state_q == FB_LEAD);
    assign err_o       = err_q;
    assign err_valid_o = err_valid_q;
    assign slip_o      = slip_q;

endmodule

// File: tb/tb_phase_freq_detector.sv
// Scoreboard bench for phase_freq_detector: two instances (CNT_W=16 and CNT_W=4) share
// stimulus; an edge-timestamp reference model predicts error words and slip pulses.
module tb_phase_freq_detector;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        ref_i;
    logic        fb_i;
    logic        up16, dn16, v16, s16;
    logic        up4, dn4, v4, s4;
    logic [15:0] err16;
    logic [3:0]  err4;

    phase_freq_detector #(.SYNC_STAGES(2), .CNT_W(16)) u16 (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .ref_i(ref_i), .fb_i(fb_i),
        .up_o(up16), .dn_o(dn16), .err_o(err16), .err_valid_o(v16), .slip_o(s16));

    phase_freq_detector #(.SYNC_STAGES(2), .CNT_W(4)) u4 (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .ref_i(ref_i), .fb_i(fb_i),
        .up_o(up4), .dn_o(dn4), .err_o(err4), .err_valid_o(v4), .slip_o(s4));

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int max_mag[2] = '{32767, 7};
    int exp_err0[$];
    int exp_err1[$];
    int lead[2];          // 0 none, 1 ref leads, 2 fb leads
    int t0[2];
    int last_err[2];
    int slip_pred[2];
    int slip_seen[2];
    int up_cnt, dn_cnt;
    int cyc;
    logic r_prev, f_prev;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic void push_err(int i, int v);
        last_err[i] = v;
        if (i == 0) exp_err0.push_back(v);
        else        exp_err1.push_back(v);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) lead[i] = 0;
    endfunction

    // Reference: remember which side rose first and when; on the other side's edge the error
    // is the timestamp difference clipped to the magnitude limit.
    function automatic void model_step(logic r, logic f);
        bit re = r & ~r_prev;
        bit fe = f & ~f_prev;
        for (int i = 0; i < 2; i++) begin
            int d = cyc - t0[i];
            int m = (d > max_mag[i]) ? max_mag[i] : d;
            if (lead[i] == 0) begin
                if (re && fe) push_err(i, 0);
                else if (re) begin lead[i] = 1; t0[i] = cyc; end
                else if (fe) begin lead[i] = 2; t0[i] = cyc; end
            end else if (lead[i] == 1) begin
                if (fe) begin
                    push_err(i, m);
                    if (re) t0[i] = cyc; else lead[i] = 0;
                end else if (re) slip_pred[i]++;
            end else begin
                if (re) begin
                    push_err(i, -m);
                    if (fe) t0[i] = cyc; else lead[i] = 0;
                end else if (fe) slip_pred[i]++;
            end
        end
    endfunction

    task automatic drive_cycle(input logic r, input logic f);
        @(negedge clk_i);
        ref_i = r;
        fb_i  = f;
        model_step(r, f);
        r_prev = r;
        f_prev = f;
        cyc++;
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) drive_cycle(r_prev, f_prev);
    endtask

    task automatic edge_pair(input int d);
        // d > 0: ref leads by d cycles; d < 0: fb leads; d == 0: simultaneous
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0);
        if (d == 0) drive_cycle(1'b1, 1'b1);
        else begin
            drive_cycle(d > 0, d < 0);
            for (int k = 1; k < ((d > 0) ? d : -d); k++) hold(1);
            drive_cycle(1'b1, 1'b1);
        end
        hold(6);
    endtask

    // Monitor: pop expected error on every strobe, count slips.
    always @(negedge clk_i) begin
        if (up16) up_cnt++;
        if (dn16) dn_cnt++;
        if (v16) begin
            if (exp_err0.size() == 0) check("u16_unexpected_strobe", 1, 0);
            else check("u16_err", $signed(err16), exp_err0.pop_front());
        end
        if (v4) begin
            if (exp_err1.size() == 0) check("u4_unexpected_strobe", 1, 0);
            else check("u4_err", $signed(err4), exp_err1.pop_front());
        end
        if (s16) slip_seen[0]++;
        if (s4)  slip_seen[1]++;
    end

    initial begin
        reset_i  = 1'b0;
        enable_i = 1'b1;
        ref_i    = 1'b0;
        fb_i     = 1'b0;
        r_prev   = 1'b0;
        f_prev   = 1'b0;
        cyc      = 0;
        up_cnt   = 0;
        dn_cnt   = 0;
        for (int i = 0; i < 2; i++) begin
            lead[i] = 0; t0[i] = 0; last_err[i] = 0; slip_pred[i] = 0; slip_seen[i] = 0;
        end
        repeat (3) @(negedge clk_i);
        check("reset_outputs", int'({up16, dn16, v16, s16, up4, dn4, v4, s4}), 0);
        check("reset_err16", int'(err16), 0);
        reset_i = 1'b1;
        hold(3);

        // ref leads fb by 5
        up_cnt = 0; dn_cnt = 0;
        edge_pair(5);
        check("t1_up_cycles", up_cnt, 5);
        check("t1_dn_cycles", dn_cnt, 0);
        check("t1_err", $signed(err16), 5);

        // fb leads ref by 3
        up_cnt = 0; dn_cnt = 0;
        edge_pair(-3);
        check("t2_err_raw", int'(err16), 32'hFFFD);
        check("t2_dn_cycles", dn_cnt, 3);
        check("t2_up_cycles", up_cnt, 0);

        // simultaneous edges
        up_cnt = 0; dn_cnt = 0;
        edge_pair(0);
        check("t3_err", int'(err16), 0);
        check("t3_updn_cycles", up_cnt + dn_cnt, 0);

        // long separation: u4 saturates at +7 / -7, u16 does not
        edge_pair(20);
        check("t4_sat_u4", $signed(err4), 7);
        check("t4_nosat_u16", $signed(err16), 20);
        edge_pair(-12);
        check("t4_negsat_u4", $signed(err4), -7);

        // ref at twice fb frequency
        drive_cycle(1'b0, 1'b0);
        for (int c = 0; c < 64; c++) drive_cycle((c % 4) < 2, ((c + 7) % 8) < 4);
        drive_cycle(1'b0, 1'b0);
        hold(6);
        check("t4_slips_u16", slip_seen[0], slip_pred[0]);
        check("t4_slips_u4", slip_seen[1], slip_pred[1]);
        check("t4_slips_seen", int'(slip_seen[0] > 0), 1);

        // drop enable mid REF_LEAD
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0);
        hold(4);
        check("t5_up_before", int'(up16), 1);
        enable_i = 1'b0;
        model_clear();
        drive_cycle(1'b1, 1'b0);
        check("t5_up_after", int'(up16), 0);
        hold(5);
        check("t5_err_hold", $signed(err16), last_err[0]);
        enable_i = 1'b1;
        hold(2);
        edge_pair(-7);
        check("t5_reenable_err", $signed(err16), -7);

        // reset mid FB_LEAD
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1);
        hold(4);
        check("t6_dn_before", int'(dn16), 1);
        @(posedge clk_i);
        #2 reset_i = 1'b0;
        #1;
        check("t6_async_flags", int'({up16, dn16, v16, s16, up4, dn4, v4, s4}), 0);
        check("t6_async_err", int'(err16) + int'(err4), 0);
        model_clear();
        last_err[0] = 0;
        last_err[1] = 0;
        ref_i = 1'b0; fb_i = 1'b0; r_prev = 1'b0; f_prev = 1'b0;
        hold(3);
        reset_i = 1'b1;
        hold(2);
        edge_pair(9);
        check("t6_after_reset_err", $signed(err16), 9);

        // randomized toggling
        for (int c = 0; c < 600; c++)
            drive_cycle(($urandom_range(3) == 0) ? ~r_prev : r_prev,
                        ($urandom_range(3) == 0) ? ~f_prev : f_prev);
        hold(8);
        check("rand_queue_u16_empty", exp_err0.size(), 0);
        check("rand_queue_u4_empty", exp_err1.size(), 0);
        check("rand_slips_u16", slip_seen[0], slip_pred[0]);
        check("rand_slips_u4", slip_seen[1], slip_pred[1]);
        check("final_err16_last", $signed(err16), last_err[0]);
        check("final_err4_last", $signed(err4), last_err[1]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
